// File: rtl/cpu_fetch.sv
// ============================================================================
// Module   : cpu_fetch
// Purpose  : single-outstanding instruction fetch stage with redirect support
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_fetch #(
  parameter logic [18:0] RESET_PC = 19'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run_i,
  input  logic        read_inst_i,
  input  logic        jump_valid_i,
  input  logic [18:0] jump_addr_i,
  output logic        imem_en_o,
  output logic [18:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [18:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [18:0] r_pc;
  logic [31:0] r_inst;
  logic [18:0] r_pc_out;
  logic        r_valid;

  always_comb begin
    w_state_nxt = r_state;
    if (jump_valid_i) begin
      // Redirect wins over everything, including a same-cycle commit.
      w_state_nxt = run_i ? FETCH : IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = run_i ? FETCH : IDLE;
        FETCH:   w_state_nxt = RESP;
        RESP:    w_state_nxt = HOLD;
        HOLD:    if (read_inst_i) w_state_nxt = run_i ? FETCH : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_inst   <= 32'h0;
      r_pc_out <= 19'h0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (jump_valid_i) begin
        r_pc    <= jump_addr_i;
        r_valid <= 1'b0;
      end else if (r_state == RESP) begin
        r_inst   <= imem_data_i;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
      end else if (r_state == HOLD && read_inst_i) begin
        r_valid <= 1'b0;
        r_pc    <= r_pc + 19'd1;
      end
    end
  end

  assign imem_en_o    = (r_state == FETCH);
  assign imem_addr_o  = r_pc;
  assign inst_valid_o = r_valid;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc_out;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch.sv
// ============================================================================
// Module   : tb_cpu_fetch
// Purpose  : directed self-checking bench for cpu_fetch
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run_i;
  logic        read_inst_i;
  logic        jump_valid_i;
  logic [18:0] jump_addr_i;
  logic        imem_en_o;
  logic [18:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [18:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_fetch #(.RESET_PC(19'h0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .run_i        (run_i),
    .read_inst_i  (read_inst_i),
    .jump_valid_i (jump_valid_i),
    .jump_addr_i  (jump_addr_i),
    .imem_en_o    (imem_en_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o)
  );

  always #5 clk = ~clk;

  // Memory contents: word 0 is fixed, every other word encodes its address.
  function automatic logic [31:0] memf(input logic [18:0] a);
    return (a == 19'h0) ? 32'hB800_1234 : {13'h1A5, a};
  endfunction

  always @(posedge clk) begin
    if (imem_en_o) imem_data_i <= memf(imem_addr_o);
    else           imem_data_i <= 32'hDEAD_BEEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    read_inst_i = 1'b1;
    step();
    read_inst_i = 1'b0;
  endtask

  initial begin
    resetn       = 1'b0;
    run_i        = 1'b0;
    read_inst_i  = 1'b0;
    jump_valid_i = 1'b0;
    jump_addr_i  = 19'h0;
    imem_data_i  = 32'h0;
    step();
    step();
    chk("rst_en",    {31'h0, imem_en_o},    32'h0);
    chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_inst",  inst_o,                32'h0);
    chk("rst_pc",    {13'h0, pc_o},         32'h0);
    chk("rst_addr",  {13'h0, imem_addr_o},  32'h0);

    // First fetch after reset
    resetn = 1'b1;
    run_i  = 1'b1;
    step();
    chk("f0_en",   {31'h0, imem_en_o},    32'h1);
    chk("f0_addr", {13'h0, imem_addr_o},  32'h0);
    step();
    chk("r0_en",    {31'h0, imem_en_o},    32'h0);
    chk("r0_valid", {31'h0, inst_valid_o}, 32'h0);
    step();
    chk("h0_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("h0_inst",  inst_o,                32'hB800_1234);
    chk("h0_pc",    {13'h0, pc_o},         32'h0);
    step();
    chk("h0_stable_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("h0_stable_en",    {31'h0, imem_en_o},    32'h0);

    // Commit -> refetch at pc+1
    consume();
    chk("c1_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("c1_en",    {31'h0, imem_en_o},    32'h1);
    chk("c1_addr",  {13'h0, imem_addr_o},  32'h1);
    step();
    step();
    chk("h1_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("h1_pc",    {13'h0, pc_o},         32'h1);
    chk("h1_inst",  inst_o,                memf(19'h1));

    for (int i = 0; i < 4; i++) begin
      consume();
      step();
      step();
    end
    chk("h5_pc", {13'h0, pc_o}, 32'h5);

    // Redirect coincident with commit: no increment
    jump_valid_i = 1'b1;
    jump_addr_i  = 19'h00040;
    consume();
    jump_valid_i = 1'b0;
    chk("jc_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("jc_en",    {31'h0, imem_en_o},    32'h1);
    chk("jc_addr",  {13'h0, imem_addr_o},  32'h40);
    step();
    chk("jc_resp_valid", {31'h0, inst_valid_o}, 32'h0);
    step();
    chk("jc_pc",   {13'h0, pc_o}, 32'h40);
    chk("jc_inst", inst_o,        memf(19'h40));

    // Redirect during RESP discards the captured word
    consume();
    chk("jr_addr0", {13'h0, imem_addr_o}, 32'h41);
    step();
    jump_valid_i = 1'b1;
    jump_addr_i  = 19'h00100;
    step();
    jump_valid_i = 1'b0;
    chk("jr_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("jr_inst",  inst_o,                memf(19'h40));
    chk("jr_pc",    {13'h0, pc_o},         32'h40);
    chk("jr_addr",  {13'h0, imem_addr_o},  32'h100);
    chk("jr_en",    {31'h0, imem_en_o},    32'h1);
    step();
    step();
    chk("jr_new_pc",   {13'h0, pc_o}, 32'h100);
    chk("jr_new_inst", inst_o,        memf(19'h100));

    // Wrap at top of address space
    jump_valid_i = 1'b1;
    jump_addr_i  = 19'h7FFFF;
    step();
    jump_valid_i = 1'b0;
    chk("w_addr", {13'h0, imem_addr_o}, 32'h7FFFF);
    step();
    step();
    chk("w_pc", {13'h0, pc_o}, 32'h7FFFF);
    consume();
    chk("w_wrap_addr", {13'h0, imem_addr_o}, 32'h0);
    chk("w_wrap_en",   {31'h0, imem_en_o},   32'h1);
    step();
    step();
    chk("w_wrap_inst", inst_o, 32'hB800_1234);

    // run_i dropped during FETCH
    consume();
    chk("rd_fetch_addr", {13'h0, imem_addr_o}, 32'h1);
    run_i = 1'b0;
    step();
    step();
    chk("rd_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("rd_pc",    {13'h0, pc_o},         32'h1);
    consume();
    chk("rd_idle_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rd_idle_en",    {31'h0, imem_en_o},    32'h0);
    step();
    step();
    chk("rd_idle_en2", {31'h0, imem_en_o}, 32'h0);
    run_i = 1'b1;
    step();
    chk("rd_resume_en",   {31'h0, imem_en_o},   32'h1);
    chk("rd_resume_addr", {13'h0, imem_addr_o}, 32'h2);

    // Reset while in RESP
    step();
    resetn = 1'b0;
    #1;
    chk("ar_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("ar_inst",  inst_o,                32'h0);
    chk("ar_addr",  {13'h0, imem_addr_o},  32'h0);
    chk("ar_en",    {31'h0, imem_en_o},    32'h0);
    run_i = 1'b0;
    step();
    resetn = 1'b1;
    step();
    step();
    chk("ar_post_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("ar_post_en",    {31'h0, imem_en_o},    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 19'h0, meaning the instruction word address fetched first after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port run_i  input  1  fetch enable; new fetches start only while high.
REQ-005 SHALL have port read_inst_i  input  1  one-cycle pulse from decode: held instruction consumed.
REQ-006 SHALL have port jump_valid_i  input  1  one-cycle redirect strobe from execute.
REQ-007 SHALL have port jump_addr_i  input  19  redirect target word address.
REQ-008 SHALL have port imem_en_o  output  1  instruction memory read enable.
REQ-009 SHALL have port imem_addr_o  output  19  instruction memory word address.
REQ-010 SHALL have port imem_data_i  input  32  read data, valid exactly one cycle after the imem_en_o cycle.
REQ-011 SHALL have port inst_valid_o  output  1  inst_o/pc_o hold an instruction for decode.
REQ-012 SHALL have port inst_o  output  32  instruction word to decode.
REQ-013 SHALL have port pc_o  output  19  word address of inst_o.

Function
REQ-014 SHALL implement states IDLE, FETCH, RESP, HOLD, with an internal 19-bit fetch pointer pc_r.
REQ-015 SHALL drive imem_en_o = 1 exactly when state is FETCH, and imem_addr_o = pc_r at all times.
REQ-016 IDLE: next FETCH if run_i = 1, else remain IDLE.
REQ-017 FETCH: next RESP unconditionally (absent redirect).
REQ-018 RESP: capture imem_data_i into inst_o and pc_r into pc_o, set inst_valid_o = 1, next HOLD.
REQ-019 HOLD: outputs stable; on read_inst_i = 1, clear inst_valid_o, pc_r <= pc_r + 1, next FETCH if run_i = 1 else IDLE.
REQ-020 SHALL ignore read_inst_i in any state other than HOLD.
REQ-021 pc_r increment SHALL wrap 19'h7FFFF -> 19'h00000 with no flag.
REQ-022 Latency: inst_valid_o SHALL rise two cycles after the imem_en_o cycle (en cycle F, data cycle F+1, valid from F+2).
REQ-023 Redirect: jump_valid_i = 1 in any state SHALL, at that edge, load pc_r <= jump_addr_i, clear inst_valid_o, and go to FETCH if run_i = 1 else IDLE.
REQ-024 Redirect in RESP SHALL discard imem_data_i; inst_o and pc_o SHALL NOT update.
REQ-025 Redirect in FETCH SHALL let the in-flight read complete unobserved; the next FETCH SHALL use the new pc_r.
REQ-026 Simultaneous jump_valid_i and read_inst_i SHALL act as a redirect only; pc_r SHALL NOT be incremented.
REQ-027 Because inst_valid_o clears on the same edge as decode's commit, a redirect arriving with the commit SHALL guarantee decode never samples the stale prefetched instruction.
REQ-028 run_i deassertion SHALL NOT abort FETCH or RESP; the in-flight instruction SHALL complete into HOLD.
REQ-029 inst_o and pc_o SHALL change only in RESP (non-redirected) or at reset.

Reset
REQ-030 On resetn low, asynchronously: state = IDLE, pc_r = RESET_PC, inst_valid_o = 0, inst_o = 32'h0, pc_o = 19'h0; imem_en_o therefore 0.
REQ-031 Reset mid-fetch SHALL discard any in-flight memory response.
REQ-032 The first fetch after reset SHALL use address RESET_PC.

Verification
REQ-033 Reset release, run_i = 1, memory[0] = 32'hB800_1234: imem_en_o high with addr 0 in cycle 2, inst_valid_o = 1, inst_o = 32'hB800_1234, pc_o = 0 from cycle 4.
REQ-034 HOLD, read_inst_i pulse: inst_valid_o = 0 next cycle, imem_en_o with addr 1 that cycle, valid again with pc_o = 1 two cycles later.
REQ-035 HOLD with pc_o = 5, jump_valid_i = 1, jump_addr_i = 19'h00040, same cycle as read_inst_i: next fetch addr 19'h00040, never addr 6, inst_valid_o low until the new word arrives.
REQ-036 jump_valid_i = 1 during RESP: the captured word is discarded, inst_o is unchanged, next imem_addr_o = jump_addr_i.
REQ-037 pc_r = 19'h7FFFF consumed: next imem_addr_o = 19'h00000.
REQ-038 run_i dropped during FETCH: instruction still reaches HOLD; after read_inst_i the state is IDLE, imem_en_o stays 0 until run_i returns, then fetch from pc + 1.
